// File: rtl/dhm_core_pkg.sv
// Shared types and defaults for the DHM core-side echo engine.
// Holds the state encoding, byte type and default packet constants.
package dhm_core_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        RX   = 2'd0,
        PROC = 2'd1,
        TX   = 2'd2
    } state_t;

    localparam int    NBYTES_DEF = 8;
    localparam byte_t KEY_DEF    = 8'hA5;

endpackage

// File: rtl/dhm_core_xform.sv
// Combinational packet transform: reverse byte order, XOR key and count.
// Ports: data (packet in), key, count -> result (packet out).
module dhm_core_xform
    import dhm_core_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  byte_t [NBYTES-1:0] data,
    input  byte_t              key,
    input  byte_t              count,
    output byte_t [NBYTES-1:0] result
);

    always_comb begin
        result = '0;
        for (int k = 0; k < NBYTES; k++) begin
            result[k] = data[NBYTES-1-k] ^ key ^ count;
        end
    end

endmodule

// File: rtl/dhm_core_echo.sv
// Core-side packet engine: receives NBYTES bytes, transforms, returns them.
// Ports: clk/reset, inbound i_rdata/i_rval/o_rrdy, outbound
// o_tdata/o_tval/i_trdy, status o_busy and o_pkt_count.
module dhm_core_echo
    import dhm_core_pkg::*;
#(
    parameter int    NBYTES = NBYTES_DEF,
    parameter byte_t KEY    = KEY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_rdata,
    input  logic       i_rval,
    output logic       o_rrdy,
    output logic [7:0] o_tdata,
    output logic       o_tval,
    input  logic       i_trdy,
    output logic       o_busy,
    output logic [7:0] o_pkt_count
);

    localparam int             IW   = $clog2(NBYTES);
    localparam logic [IW-1:0]  LAST = IW'(NBYTES - 1);

    state_t                state;
    logic   [IW-1:0]       idx;
    logic   [IW-1:0]       idx_nxt;
    byte_t  [NBYTES-1:0]   in_q;
    byte_t  [NBYTES-1:0]   out_q;
    byte_t  [NBYTES-1:0]   xf;

    assign idx_nxt = idx + IW'(1);

    // Count uses its pre-increment value: it only advances after TX.
    dhm_core_xform #(
        .NBYTES (NBYTES)
    ) u_xform (
        .data   (in_q),
        .key    (KEY),
        .count  (o_pkt_count),
        .result (xf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RX;
            idx         <= '0;
            in_q        <= '0;
            out_q       <= '0;
            o_rrdy      <= 1'b1;
            o_tval      <= 1'b0;
            o_tdata     <= '0;
            o_busy      <= 1'b0;
            o_pkt_count <= '0;
        end else begin
            unique case (state)
                RX: begin
                    if (i_rval && o_rrdy) begin
                        in_q[idx] <= i_rdata;
                        o_busy    <= 1'b1;
                        if (idx == LAST) begin
                            idx    <= '0;
                            o_rrdy <= 1'b0;
                            state  <= PROC;
                        end else begin
                            idx <= idx_nxt;
                        end
                    end
                end
                PROC: begin
                    out_q   <= xf;
                    o_tval  <= 1'b1;
                    o_tdata <= xf[0];
                    state   <= TX;
                end
                TX: begin
                    if (o_tval && i_trdy) begin
                        if (idx == LAST) begin
                            idx         <= '0;
                            o_tval      <= 1'b0;
                            o_rrdy      <= 1'b1;
                            o_busy      <= 1'b0;
                            o_pkt_count <= o_pkt_count + 8'd1;
                            state       <= RX;
                        end else begin
                            idx     <= idx_nxt;
                            o_tdata <= out_q[idx_nxt];
                        end
                    end
                end
                default: begin
                    state <= RX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dhm_core_echo.sv
// Scoreboard bench for dhm_core_echo: directed packets, stalls, reset.
// Driver pushes expected bytes; a negedge monitor pops and compares.
module tb_dhm_core_echo;
    import dhm_core_pkg::*;

    localparam int N = 8;
    typedef logic [7:0] pkt_t [N];

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i_rdata;
    logic       i_rval;
    logic       o_rrdy;
    logic [7:0] o_tdata;
    logic       o_tval;
    logic       i_trdy;
    logic       o_busy;
    logic [7:0] o_pkt_count;

    always #5 clk = ~clk;

    dhm_core_echo #(
        .NBYTES (N),
        .KEY    (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rdata     (i_rdata),
        .i_rval      (i_rval),
        .o_rrdy      (o_rrdy),
        .o_tdata     (o_tdata),
        .o_tval      (o_tval),
        .i_trdy      (i_trdy),
        .o_busy      (o_busy),
        .o_pkt_count (o_pkt_count)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cnt_m;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Hand-computed expected bytes for one packet.
    task automatic push_tab(input pkt_t e);
        for (int k = 0; k < N; k++) exp_q.push_back(e[k]);
        cnt_m = cnt_m + 8'd1;
    endtask

    // Reference transform for the longer runs.
    task automatic push_model(input pkt_t d);
        for (int k = 0; k < N; k++)
            exp_q.push_back(d[N-1-k] ^ 8'hA5 ^ cnt_m);
        cnt_m = cnt_m + 8'd1;
    endtask

    task automatic send(input pkt_t d, input bit gaps,
                        input bit hold_ff, input int nb);
        int g;
        for (int k = 0; k < nb; k++) begin
            i_rval  = 1'b1;
            i_rdata = d[k];
            g = 0;
            while (!o_rrdy && g < 100) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 100) chk("rrdy_timeout", 0, 1);
            @(posedge clk); #1;
            if (gaps && k < nb - 1) begin
                i_rval = 1'b0;
                @(posedge clk); #1;
            end
        end
        if (hold_ff) begin
            i_rval  = 1'b1;
            i_rdata = 8'hFF;
        end else begin
            i_rval = 1'b0;
        end
    endtask

    task automatic wait_done(input bit stall);
        int g;
        if (stall) begin
            g = 0;
            while (!o_tval && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
            repeat (3) begin @(posedge clk); #1; end
            i_trdy = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            i_trdy = 1'b1;
        end
        g = 0;
        while ((o_busy || exp_q.size() != 0) && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        chk("done_in_time", 32'(g < 300), 1);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        i_rval = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        cnt_m = 8'd0;
        exp_q.delete();
        chk("rst_rrdy",  o_rrdy,      1);
        chk("rst_tval",  o_tval,      0);
        chk("rst_tdata", o_tdata,     0);
        chk("rst_count", o_pkt_count, 0);
        chk("rst_busy",  o_busy,      0);
    endtask

    // Monitor: scoreboard pops, latency, stall hold, handshake exclusion.
    int         cyc     = 0;
    int         last_in = 0;
    logic       prev_tval = 1'b0;
    logic       held_v    = 1'b0;
    logic [7:0] held_d;
    logic [7:0] e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            held_v    = 1'b0;
            prev_tval = 1'b0;
        end else begin
            if (i_rval && o_rrdy) last_in = cyc;
            if (o_tval && !prev_tval)
                chk("latency", 32'(cyc - last_in), 2);
            if (o_rrdy && o_tval) chk("rrdy_tval_excl", 1, 0);
            if (o_tval && i_trdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, o_tdata}, 32'h100);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", o_tdata, e);
                end
            end
            if (o_tval && !i_trdy) begin
                if (held_v) chk("stall_hold", o_tdata, held_d);
                held_v = 1'b1;
                held_d = o_tdata;
            end else begin
                held_v = 1'b0;
            end
            prev_tval = o_tval;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    pkt_t p_inc, p_alt, p_zero, exp_a, exp_b;

    initial begin
        p_inc  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        p_alt  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        p_zero = '{default: 8'h00};
        exp_a  = '{8'hAD, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA6, 8'hA7, 8'hA4};
        exp_b  = '{8'hAC, 8'hA3, 8'hA2, 8'hA1, 8'hA0, 8'hA7, 8'hA6, 8'hA5};
        i_rdata = 8'h00;
        i_trdy  = 1'b1;
        cnt_m   = 8'd0;
        do_reset();

        // Basic packet, count 0 then count 1.
        push_tab(exp_a);
        send(p_inc, 1'b0, 1'b0, N);
        wait_done(1'b0);
        chk("count_after_1", o_pkt_count, 1);

        push_tab(exp_b);
        send(p_inc, 1'b0, 1'b0, N);
        wait_done(1'b0);
        chk("count_after_2", o_pkt_count, 2);

        // Input gaps and a 3-cycle output stall.
        push_model(p_inc);
        send(p_inc, 1'b1, 1'b0, N);
        wait_done(1'b1);
        chk("count_after_stall", o_pkt_count, 3);

        // i_rval held with FF during PROC/TX must be ignored.
        push_model(p_alt);
        send(p_alt, 1'b0, 1'b1, N);
        wait_done(1'b0);
        push_model(p_inc);
        send(p_inc, 1'b0, 1'b0, N);
        wait_done(1'b0);
        chk("count_after_hold", o_pkt_count, 5);

        // Reset after a partial packet discards it.
        send(p_inc, 1'b0, 1'b0, 4);
        chk("partial_busy", o_busy, 1);
        do_reset();
        push_tab(exp_a);
        send(p_inc, 1'b0, 1'b0, N);
        wait_done(1'b0);
        chk("count_after_rst", o_pkt_count, 1);

        // Count wrap over 256 packets of zeros.
        do_reset();
        for (int p = 0; p < 256; p++) begin
            push_model(p_zero);
            send(p_zero, 1'b0, 1'b0, N);
            wait_done(1'b0);
            chk("count_run", o_pkt_count, 32'((p + 1) % 256));
        end
        chk("count_wrapped", o_pkt_count, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
